// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester byte streams, uart_top TX handshake and arbiter status
interface uart_tx_arbiter_if #(
    parameter int N = 4,
    parameter int IDW = 2
);
    logic [N-1:0] req_valid;
    logic [N*8-1:0] req_data;
    logic [N-1:0] req_last;
    logic [N-1:0] req_ready;
    logic uart_tx_valid;
    logic [7:0] uart_in;
    logic uart_tx_ready;
    logic [IDW-1:0] grant_id;
    logic busy;
    logic abort;
    modport slave (
        input req_valid, req_data, req_last, uart_tx_ready,
        output req_ready, uart_tx_valid, uart_in, grant_id, busy, abort
    );
    modport master (
        output req_valid, req_data, req_last, uart_tx_ready,
        input req_ready, uart_tx_valid, uart_in, grant_id, busy, abort
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: frame-granular round-robin sharing of the uart_top TX port; UART_ARB_TIMEOUT_EN adds stall release with abort
module uart_tx_arbiter #(
    parameter int N = 4,
    parameter int IDW = 2,
    parameter int MAX_FRAME = 16,
    parameter int TIMEOUT_CYCLES = 8700
) (
    input logic clk,
    input logic rst,
    uart_tx_arbiter_if.slave bus
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t state_q, state_d;
    logic [IDW-1:0] grant_q, grant_d, last_q, last_d, pick, idx;
    logic [7:0] cnt_q, cnt_d;
    logic found, in_grant, accept, timeout, release_c;
    always_comb begin
        found = 1'b0;
        pick = '0;
        idx = '0;
        for (int i = 1; i <= N; i++) begin
            idx = IDW'((int'(last_q) + i) % N);
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                pick = idx;
            end
        end
    end
    assign in_grant = state_q == GRANT;
    assign accept = in_grant && bus.req_valid[grant_q] && bus.uart_tx_ready;
    assign release_c = timeout || (accept && (bus.req_last[grant_q] || cnt_q == 8'(MAX_FRAME - 1)));
    assign bus.uart_tx_valid = in_grant && bus.req_valid[grant_q];
    assign bus.uart_in = in_grant ? bus.req_data[{grant_q, 3'b000} +: 8] : 8'h00;
    assign bus.req_ready = in_grant ? N'(bus.uart_tx_ready) << grant_q : '0;
    assign bus.grant_id = grant_q;
    assign bus.busy = in_grant;
`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0] stall_q, stall_d;
    logic abort_q;
    assign stall_d = (in_grant && !bus.req_valid[grant_q]) ? stall_q + 16'd1 : 16'd0;
    assign timeout = in_grant && !bus.req_valid[grant_q] && stall_q == 16'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            abort_q <= 1'b0;
        end else begin
            stall_q <= stall_d;
            abort_q <= timeout;
        end
    end
    assign bus.abort = abort_q;
`else
    assign timeout = TIMEOUT_CYCLES < 0;
    assign bus.abort = 1'b0;
`endif
    // grant_id reads 0 while idle; last_q alone carries the rotation point
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d = last_q;
        cnt_d = accept ? cnt_q + 8'd1 : cnt_q;
        if (!in_grant && found) begin
            state_d = GRANT;
            grant_d = pick;
        end else if (release_c) begin
            state_d = IDLE;
            grant_d = '0;
            last_d = grant_q;
            cnt_d = '0;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q <= IDW'(N - 1);
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q <= last_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized checks of uart_tx_arbiter against a round-robin frame model
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int N = 4;
    localparam int MAXF = 16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    uart_tx_arbiter_if #(.N(N), .IDW(2)) bus ();
    uart_tx_arbiter #(.N(N), .IDW(2), .MAX_FRAME(MAXF), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;

    logic [8:0] mem [N][64];
    int ln [N];
    int hd [N];
    int st [N];
    int rdy_pct = 100;
    int rdy_period = 0;
    logic [3:0] acc_mask [$];
    logic [1:0] acc_gid [$];
    logic [7:0] acc_byte [$];
    logic acc_uv [$];
    int acc_cyc [$];

    task automatic idle_inputs();
        bus.req_valid = '0;
        bus.req_data = '0;
        bus.req_last = '0;
        bus.uart_tx_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clear_streams();
        for (int k = 0; k < N; k++) begin
            ln[k] = 0;
            hd[k] = 0;
            st[k] = 0;
        end
        acc_mask.delete();
        acc_gid.delete();
        acc_byte.delete();
        acc_uv.delete();
        acc_cyc.delete();
    endtask

    // drives every requester from its byte list and logs each transfer cycle
    task automatic run_streams(input int max_cyc, input int stop_after);
        int c = 0;
        int pend;
        logic [3:0] fire;
        do begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                bus.req_valid[k] = (c >= st[k]) && (hd[k] < ln[k]);
                bus.req_data[k*8 +: 8] = bus.req_valid[k] ? mem[k][hd[k]][7:0] : 8'h00;
                bus.req_last[k] = bus.req_valid[k] && mem[k][hd[k]][8];
            end
            bus.uart_tx_ready = rdy_period > 0 ? (c % rdy_period == rdy_period - 1) : ($urandom_range(99) < rdy_pct);
            #1;
            fire = bus.req_valid & bus.req_ready;
            if (fire != 0 || (bus.uart_tx_valid && bus.uart_tx_ready)) begin
                acc_mask.push_back(fire);
                acc_gid.push_back(bus.grant_id);
                acc_byte.push_back(bus.uart_in);
                acc_uv.push_back(bus.uart_tx_valid && bus.uart_tx_ready);
                acc_cyc.push_back(c);
                for (int k = 0; k < N; k++) if (fire[k]) hd[k]++;
            end
            pend = 0;
            for (int k = 0; k < N; k++) if (hd[k] < ln[k]) pend++;
            c++;
        end while (pend > 0 && c < max_cyc && (stop_after == 0 || acc_mask.size() < stop_after));
        @(negedge clk);
        idle_inputs();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        bus.req_valid = 4'hF;
        bus.req_data = 32'h44332211;
        bus.uart_tx_ready = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.grant_id, bus.uart_tx_valid, bus.uart_in, bus.req_ready, bus.abort} !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: busy %b gid %0d txv %b in %h rdy %b abort %b, required all 0",
                     bus.busy, bus.grant_id, bus.uart_tx_valid, bus.uart_in, bus.req_ready, bus.abort);
        end
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.grant_id, bus.uart_tx_valid, bus.uart_in, bus.req_ready, bus.abort} !== 16'h0) begin
            errors++;
            $display("FAIL idle_after_reset: busy %b gid %0d txv %b in %h rdy %b, required all 0",
                     bus.busy, bus.grant_id, bus.uart_tx_valid, bus.uart_in, bus.req_ready);
        end
    endtask

    task automatic test_single_frame();
        do_reset();
        clear_streams();
        mem[1][0] = 9'h0A1;
        mem[1][1] = 9'h0A2;
        mem[1][2] = 9'h1A3;
        ln[1] = 3;
        rdy_period = 8;
        run_streams(200, 0);
        rdy_period = 0;
        checks++;
        if (bus.busy !== 1'b0 || bus.grant_id !== 2'd0) begin
            errors++;
            $display("FAIL single_release: busy %b gid %0d, required busy 0 gid 0", bus.busy, bus.grant_id);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= acc_mask.size()) begin
                errors++;
                $display("FAIL single_byte%0d: got nothing, required %h", i, 8'(8'hA1 + i));
            end else if (acc_mask[i] !== 4'b0010 || acc_gid[i] !== 2'd1 || acc_byte[i] !== 8'(8'hA1 + i) || acc_uv[i] !== 1'b1) begin
                errors++;
                $display("FAIL single_byte%0d: got mask %b gid %0d data %h uv %b, required 0010 1 %h 1",
                         i, acc_mask[i], acc_gid[i], acc_byte[i], acc_uv[i], 8'(8'hA1 + i));
            end
        end
    endtask

    task automatic test_rotation();
        int eid [5] = '{0, 2, 3, 0, 3};
        logic [7:0] eb [5] = '{8'h10, 8'h30, 8'h40, 8'h11, 8'h41};
        do_reset();
        for (int ph = 0; ph < 2; ph++) begin
            clear_streams();
            rdy_pct = 100;
            if (ph == 0) begin
                mem[0][0] = 9'h110; mem[2][0] = 9'h130; mem[3][0] = 9'h140;
                ln[0] = 1; ln[2] = 1; ln[3] = 1;
            end else begin
                mem[0][0] = 9'h111; mem[3][0] = 9'h141;
                ln[0] = 1; ln[3] = 1;
            end
            run_streams(100, 0);
            for (int i = 0; i < 3 - ph; i++) begin
                int j = ph * 3 + i;
                checks++;
                if (i >= acc_mask.size()) begin
                    errors++;
                    $display("FAIL rotation%0d: got nothing, required id %0d", j, eid[j]);
                end else if (acc_mask[i] !== 4'(1 << eid[j]) || acc_gid[i] !== 2'(eid[j]) || acc_byte[i] !== eb[j]) begin
                    errors++;
                    $display("FAIL rotation%0d: got mask %b gid %0d data %h, required id %0d data %h",
                             j, acc_mask[i], acc_gid[i], acc_byte[i], eid[j], eb[j]);
                end
                if (i > 0 && i < acc_cyc.size()) begin
                    checks++;
                    if (acc_cyc[i] - acc_cyc[i-1] != 2) begin
                        errors++;
                        $display("FAIL rotation_gap%0d: got %0d cycles, required 2", j, acc_cyc[i] - acc_cyc[i-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_max_frame();
        do_reset();
        clear_streams();
        for (int i = 0; i < 20; i++) mem[2][i] = {1'b0, 8'(8'h60 + i)};
        ln[2] = 20;
        mem[0][0] = 9'h155;
        ln[0] = 1;
        st[0] = 3;
        rdy_pct = 100;
        run_streams(200, 0);
        checks++;
        if (acc_mask.size() != 21) begin
            errors++;
            $display("FAIL max_frame_count: got %0d transfers, required 21", acc_mask.size());
        end
        for (int i = 0; i < 21 && i < acc_mask.size(); i++) begin
            int eid = i == 16 ? 0 : 2;
            logic [7:0] eb = i == 16 ? 8'h55 : 8'(8'h60 + (i < 16 ? i : i - 1));
            checks++;
            if (acc_mask[i] !== 4'(1 << eid) || acc_gid[i] !== 2'(eid) || acc_byte[i] !== eb) begin
                errors++;
                $display("FAIL max_frame%0d: got mask %b gid %0d data %h, required id %0d data %h",
                         i, acc_mask[i], acc_gid[i], acc_byte[i], eid, eb);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        clear_streams();
        for (int i = 0; i < 5; i++) mem[1][i] = {i == 4, 8'(8'h21 + i)};
        ln[1] = 5;
        rdy_pct = 100;
        run_streams(100, 2);
        bus.req_valid = 4'b0010;
        bus.req_data = 32'h00002300;
        bus.uart_tx_ready = 1'b1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({bus.busy, bus.grant_id, bus.uart_tx_valid, bus.uart_in, bus.req_ready, bus.abort} !== 16'h0) begin
                errors++;
                $display("FAIL midreset%0d: busy %b gid %0d txv %b in %h rdy %b, required all 0",
                         i, bus.busy, bus.grant_id, bus.uart_tx_valid, bus.uart_in, bus.req_ready);
            end
            @(negedge clk);
        end
        idle_inputs();
        rst = 1'b0;
        clear_streams();
        mem[2][0] = 9'h132; mem[3][0] = 9'h133;
        ln[2] = 1; ln[3] = 1;
        run_streams(100, 0);
        checks++;
        if (acc_mask.size() < 1 || acc_gid[0] !== 2'd2 || acc_byte[0] !== 8'h32) begin
            errors++;
            $display("FAIL midreset_next: got %0d transfers first gid %0d, required gid 2 data 32",
                     acc_mask.size(), acc_mask.size() > 0 ? acc_gid[0] : 2'd0);
        end
    endtask

    task automatic test_stall();
        do_reset();
        bus.req_valid = 4'b0010;
        bus.req_data = 32'h00007700;
        bus.req_last = 4'b0010;
        @(negedge clk);
        bus.req_valid = 4'b0011;
        bus.req_data = 32'h00007711;
        bus.req_last = 4'b0011;
        for (int i = 0; i < 50; i++) begin
            #1;
            checks++;
            if (bus.grant_id !== 2'd1 || bus.busy !== 1'b1 || bus.req_ready !== 4'b0 || bus.uart_in !== 8'h77 || bus.uart_tx_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall%0d: gid %0d busy %b rdy %b in %h txv %b, required 1 1 0000 77 1",
                         i, bus.grant_id, bus.busy, bus.req_ready, bus.uart_in, bus.uart_tx_valid);
            end
            @(negedge clk);
        end
        bus.uart_tx_ready = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL stall_ready: got %b, required 0010", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = 4'b0001;
        bus.req_data = 32'h00000011;
        bus.req_last = 4'b0001;
        bus.uart_tx_ready = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_gap: busy %b, required 0", bus.busy);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b1 || bus.grant_id !== 2'd0 || bus.uart_in !== 8'h11) begin
            errors++;
            $display("FAIL stall_next: busy %b gid %0d in %h, required 1 0 11", bus.busy, bus.grant_id, bus.uart_in);
        end
        idle_inputs();
    endtask

    task automatic test_timeout();
        int n = 0;
        do_reset();
        bus.req_valid = 4'b1000;
        bus.req_data = 32'h99000000;
        bus.uart_tx_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (bus.grant_id !== 2'd3 || bus.uart_tx_valid !== 1'b1 || bus.uart_in !== 8'h99) begin
            errors++;
            $display("FAIL timeout_first: gid %0d txv %b in %h, required 3 1 99", bus.grant_id, bus.uart_tx_valid, bus.uart_in);
        end
        @(negedge clk);
        bus.req_valid = 4'b0001;
        bus.req_data = 32'h00000012;
        bus.req_last = 4'b0001;
        #1;
`ifdef UART_ARB_TIMEOUT_EN
        while (bus.busy && n < 300) begin
            n++;
            @(negedge clk);
            #1;
        end
        checks++;
        if (n != 100 || bus.abort !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_release: stall %0d abort %b busy %b, required 100 1 0", n, bus.abort, bus.busy);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.abort !== 1'b0 || bus.busy !== 1'b1 || bus.grant_id !== 2'd0) begin
            errors++;
            $display("FAIL timeout_next: abort %b busy %b gid %0d, required 0 1 0", bus.abort, bus.busy, bus.grant_id);
        end
`else
        for (int i = 0; i < 300; i++) begin
            checks++;
            if (bus.grant_id !== 2'd3 || bus.busy !== 1'b1 || bus.abort !== 1'b0) begin
                errors++;
                $display("FAIL hold%0d: gid %0d busy %b abort %b, required 3 1 0", i, bus.grant_id, bus.busy, bus.abort);
            end
            @(negedge clk);
            #1;
        end
        n = 300;
`endif
        idle_inputs();
    endtask

    // model: whole frames rotate from the last owner; a frame ends on last or MAXF bytes
    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            int owner = -1;
            int lastg = N - 1;
            int cnt = 0;
            int total = 0;
            int mh [N];
            int eid [$];
            logic [7:0] eb [$];
            bit erel [$];
            do_reset();
            clear_streams();
            for (int k = 0; k < N; k++) begin
                mh[k] = 0;
                ln[k] = $urandom_range(1, 24);
                for (int i = 0; i < ln[k]; i++) mem[k][i] = {$urandom_range(99) < 15, 8'($urandom)};
                mem[k][ln[k] - 1][8] = 1'b1;
                total += ln[k];
            end
            rdy_pct = $urandom_range(30, 100);
            run_streams(3000, 0);
            for (int n = 0; n < total; n++) begin
                bit rel;
                if (owner < 0)
                    for (int i = 1; i <= N; i++)
                        if (owner < 0 && mh[(lastg + i) % N] < ln[(lastg + i) % N]) owner = (lastg + i) % N;
                eid.push_back(owner);
                eb.push_back(mem[owner][mh[owner]][7:0]);
                cnt++;
                rel = mem[owner][mh[owner]][8] || cnt == MAXF;
                erel.push_back(rel);
                mh[owner]++;
                if (rel) begin
                    lastg = owner;
                    owner = -1;
                    cnt = 0;
                end
            end
            checks++;
            if (acc_mask.size() != total) begin
                errors++;
                $display("FAIL random%0d_count: got %0d transfers, required %0d", r, acc_mask.size(), total);
            end
            for (int i = 0; i < total && i < acc_mask.size(); i++) begin
                checks++;
                if (acc_mask[i] !== 4'(1 << eid[i]) || acc_gid[i] !== 2'(eid[i]) || acc_byte[i] !== eb[i] || acc_uv[i] !== 1'b1) begin
                    errors++;
                    $display("FAIL random%0d_byte%0d: got mask %b gid %0d data %h uv %b, required id %0d data %h",
                             r, i, acc_mask[i], acc_gid[i], acc_byte[i], acc_uv[i], eid[i], eb[i]);
                end
                if (erel[i] && i + 1 < acc_cyc.size()) begin
                    checks++;
                    if (acc_cyc[i+1] - acc_cyc[i] < 2) begin
                        errors++;
                        $display("FAIL random%0d_gap%0d: got %0d cycles, required at least 2", r, i, acc_cyc[i+1] - acc_cyc[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_frame();
        test_rotation();
        test_max_frame();
        test_reset_mid_frame();
        test_stall();
        test_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
